calc_display: RTL and testbench

Scanned 8-digit, common-anode 7-segment display driver that sits on the consumer side of the calculator's `pos`/`dig`/`status` output stream. It captures digits into an 8-entry buffer, either by direct position write or by shift-in during key entry. It applies leading-zero blanking, shows a fixed "Erro" message when the calculator reports the error state, and time-multiplexes the digits onto shared segment lines.

---
 rtl/calc_pkg.sv | 25 ++
 rtl/seg7_decode.sv | 26 ++
 rtl/calc_display.sv | 114 +++++++++++
 tb/tb_calc_display.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator types and constants.
// Used by the display driver and its decoder.
package calc_pkg;

  typedef enum logic [1:0] {
    ERRO    = 2'd0,
    PRONTA  = 2'd1,
    OCUPADA = 2'd2
  } statetype;

  localparam logic [3:0] SOMA  = 4'hA;
  localparam logic [3:0] SUBT  = 4'hB;
  localparam logic [3:0] MULT  = 4'hC;
  localparam logic [3:0] IGUAL = 4'hE;
  localparam logic [3:0] BACKS = 4'hF;

  localparam logic [3:0] POS_SHIFT = 4'hF;
  localparam int         NDIG      = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_O     = 7'h23;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low 7-segment {g,f,e,d,c,b,a}.
// Non-BCD codes render blank.
module seg7_decode (
  input  logic [3:0] d,
  output logic [6:0] seg
);
  import calc_pkg::*;

  always_comb begin
    seg = SEG_BLANK;
    unique case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_display.sv
// Scanned 8-digit common-anode display driver with
// digit buffer, leading-zero blanking and error message.
module calc_display #(
  parameter int SCAN_DIV = 50000,
  parameter int LZ_BLANK = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr,
  input  logic [3:0] pos,
  input  logic [3:0] dig,
  input  logic       clr,
  input  logic [1:0] status,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  import calc_pkg::*;

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [7:0][3:0] dbuf_q, dbuf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;

  logic [6:0] dec_seg;
  logic [6:0] err_seg;
  logic       lz_hit;
  logic       zrun;

  always_comb begin
    dbuf_d = dbuf_q;
    if (clr) begin
      dbuf_d = '0;
    end else if (wr) begin
      if (pos == POS_SHIFT) begin
        for (int i = 0; i < NDIG - 1; i++)
          dbuf_d[i] = dbuf_q[i+1];
        dbuf_d[NDIG-1] = dig;
      end else if (!pos[3]) begin
        dbuf_d[pos[2:0]] = dig;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  seg7_decode u_dec (
    .d   (dbuf_q[idx_q]),
    .seg (dec_seg)
  );

  // Slot is a leading zero if it and every slot left of it is 0.
  always_comb begin
    zrun   = 1'b1;
    lz_hit = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      zrun = zrun & (dbuf_q[i] == 4'd0);
      if (3'(i) == idx_q && i < NDIG - 1)
        lz_hit = zrun;
    end
  end

  always_comb begin
    err_seg = SEG_BLANK;
    unique case (idx_q)
      3'd4:    err_seg = SEG_E;
      3'd5:    err_seg = SEG_R;
      3'd6:    err_seg = SEG_R;
      3'd7:    err_seg = SEG_O;
      default: err_seg = SEG_BLANK;
    endcase
  end

  always_comb begin
    an_d  = ~(8'd1 << idx_q);
    seg_d = dec_seg;
    if (statetype'(status) == ERRO)
      seg_d = err_seg;
    else if (LZ_BLANK != 0 && lz_hit)
      seg_d = SEG_BLANK;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dbuf_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      an_q   <= 8'hFF;
      seg_q  <= SEG_BLANK;
    end else begin
      dbuf_q <= dbuf_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_calc_display.sv
// Self-checking bench for calc_display against a
// frame-level behavioural model of the display.
module tb_calc_display;

  localparam int SD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wr = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] pos = 4'd0;
  logic [3:0] dig = 4'd0;
  logic [1:0] status = 2'd1;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  calc_display #(.SCAN_DIV(SD), .LZ_BLANK(1)) dut (
    .clock  (clock),
    .reset  (reset),
    .wr     (wr),
    .pos    (pos),
    .dig    (dig),
    .clr    (clr),
    .status (status),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int mbuf [8];
  int k = 0;
  logic [7:0] ea;
  logic [6:0] es;
  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic int slot_of(int kk);
    return ((kk - 1) / SD) % 8;
  endfunction

  function automatic logic [6:0] ref_seg(int s, int st);
    bit lead;
    if (st == 0) begin
      case (s)
        4: return 7'h06;
        5: return 7'h2F;
        6: return 7'h2F;
        7: return 7'h23;
        default: return 7'h7F;
      endcase
    end
    lead = 1'b1;
    for (int i = 0; i <= s; i++)
      if (mbuf[i] != 0) lead = 1'b0;
    if (lead && s < 7) return 7'h7F;
    if (mbuf[s] > 9) return 7'h7F;
    return segtab[mbuf[s]];
  endfunction

  // Advance one clock; expected outputs use the buffer before this edge.
  task automatic tick();
    @(posedge clock);
    if (!reset) begin
      k = 0;
      foreach (mbuf[i]) mbuf[i] = 0;
      ea = 8'hFF;
      es = 7'h7F;
    end else begin
      k++;
      ea = ~(8'd1 << slot_of(k));
      es = ref_seg(slot_of(k), int'(status));
      if (clr) begin
        foreach (mbuf[i]) mbuf[i] = 0;
      end else if (wr) begin
        if (pos == 4'hF) begin
          for (int i = 0; i < 7; i++) mbuf[i] = mbuf[i+1];
          mbuf[7] = int'(dig);
        end else if (pos < 4'd8) begin
          mbuf[pos] = int'(dig);
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1)
        $display("FAIL reset_hold an=%h exp=FF seg=%h exp=7F dp=%b",
                 an, seg, dp);
      else passed++;
    end
    reset = 1'b1;
    for (int c = 0; c < 8 * SD; c++) begin
      tick();
      total++;
      if (an !== ea || seg !== es || dp !== 1'b1)
        $display("FAIL reset_frame k=%0d an=%h exp=%h seg=%h exp=%h",
                 k, an, ea, seg, es);
      else passed++;
    end
  endtask

  task automatic test_shift();
    for (int d = 1; d <= 3; d++) begin
      wr = 1'b1; pos = 4'hF; dig = 4'(d);
      tick();
      wr = 1'b0;
      total++;
      if (an !== ea || seg !== es)
        $display("FAIL shift_wr k=%0d an=%h exp=%h seg=%h exp=%h",
                 k, an, ea, seg, es);
      else passed++;
    end
    for (int c = 0; c < 8 * SD; c++) begin
      tick();
      total++;
      if (an !== ea || seg !== es)
        $display("FAIL shift_frame k=%0d an=%h exp=%h seg=%h exp=%h",
                 k, an, ea, seg, es);
      else passed++;
      if (slot_of(k) == 7) begin
        total++;
        if (seg !== 7'h30)
          $display("FAIL shift_lsd seg=%h exp=30", seg);
        else passed++;
      end
    end
  endtask

  task automatic test_direct();
    for (int p = 0; p < 9; p++) begin
      wr = 1'b1;
      pos = (p == 8) ? 4'd9 : 4'(p);
      dig = (p == 8) ? 4'd1 : 4'(9 - p);
      tick();
      wr = 1'b0;
      total++;
      if (an !== ea || seg !== es)
        $display("FAIL direct_wr k=%0d an=%h exp=%h seg=%h exp=%h",
                 k, an, ea, seg, es);
      else passed++;
    end
    for (int c = 0; c < 8 * SD; c++) begin
      tick();
      total++;
      if (an !== ea || seg !== es)
        $display("FAIL direct_frame k=%0d an=%h exp=%h seg=%h exp=%h",
                 k, an, ea, seg, es);
      else passed++;
      if (slot_of(k) == 0) begin
        total++;
        if (seg !== 7'h10)
          $display("FAIL direct_msd seg=%h exp=10", seg);
        else passed++;
      end
    end
  endtask

  task automatic test_erro();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int d = 1; d <= 3; d++) begin
      wr = 1'b1; pos = 4'hF; dig = 4'(d);
      tick();
      wr = 1'b0;
    end
    for (int ph = 0; ph < 2; ph++) begin
      status = (ph == 0) ? 2'd0 : 2'd1;
      for (int c = 0; c < 8 * SD; c++) begin
        tick();
        total++;
        if (an !== ea || seg !== es)
          $display("FAIL erro_ph%0d k=%0d an=%h exp=%h seg=%h exp=%h",
                   ph, k, an, ea, seg, es);
        else passed++;
      end
    end
  endtask

  task automatic test_clr_wr();
    clr = 1'b1; wr = 1'b1; pos = 4'd7; dig = 4'd5;
    tick();
    clr = 1'b0; wr = 1'b0;
    for (int c = 0; c < 8 * SD; c++) begin
      tick();
      total++;
      if (an !== ea || seg !== es)
        $display("FAIL clr_wr k=%0d an=%h exp=%h seg=%h exp=%h",
                 k, an, ea, seg, es);
      else passed++;
      if (slot_of(k) == 7) begin
        total++;
        if (seg !== 7'h40)
          $display("FAIL clr_wr_lsd seg=%h exp=40", seg);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    wr = 1'b1; pos = 4'd7; dig = 4'd4;
    tick();
    wr = 1'b0;
    while (slot_of(k) != 5 && guard < 100) begin
      tick();
      guard++;
    end
    total++;
    if (an !== 8'hDF)
      $display("FAIL mid_slot5 an=%h exp=DF", an);
    else passed++;
    #2 reset = 1'b0;
    #1;
    total++;
    if (an !== 8'hFF || seg !== 7'h7F)
      $display("FAIL mid_async an=%h exp=FF seg=%h exp=7F", an, seg);
    else passed++;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 8 * SD; c++) begin
      tick();
      total++;
      if (an !== ea || seg !== es)
        $display("FAIL mid_resume k=%0d an=%h exp=%h seg=%h exp=%h",
                 k, an, ea, seg, es);
      else passed++;
      if (k == 1) begin
        total++;
        if (an !== 8'hFE)
          $display("FAIL mid_slot0 an=%h exp=FE", an);
        else passed++;
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      wr  = 1'($urandom_range(0, 1));
      pos = 4'($urandom_range(0, 15));
      dig = 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0)
        status = 2'($urandom_range(0, 3));
      tick();
      total++;
      if (an !== ea || seg !== es || dp !== 1'b1)
        $display("FAIL random k=%0d an=%h exp=%h seg=%h exp=%h",
                 k, an, ea, seg, es);
      else passed++;
    end
    wr = 1'b0; clr = 1'b0; status = 2'd1;
  endtask

  initial begin
    test_reset();
    test_shift();
    test_direct();
    test_erro();
    test_clr_wr();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
